// File: rtl/tt_eval_pkg.sv
// tt_eval_pkg: shared config-FSM states and width helpers for tt_logic_eval
package tt_eval_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, COMMIT} cfg_state_e;
  localparam int N_IN_MAX = 8;
  function automatic int tt_width(input int n);
    return 1 << n;
  endfunction
endpackage

// File: rtl/tt_cfg_loader.sv
// tt_cfg_loader: serial truth-table loader; shifts bits MSB first and pulses commit once a full table has arrived
module tt_cfg_loader
  import tt_eval_pkg::*;
#(
  parameter int TT_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_valid,
  output logic            cfg_ready,
  input  logic            cfg_bit,
  input  logic            cfg_abort,
  output logic            cfg_busy,
  output logic            commit,
  output logic [TT_W-1:0] shadow
);
  localparam int CW = $clog2(TT_W) + 1;
  cfg_state_e state;
  logic [CW-1:0] count;
  assign cfg_ready = state != COMMIT;
  assign cfg_busy = state != IDLE;
  assign commit = state == COMMIT;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      shadow <= '0;
    end else begin
      case (state)
        IDLE: if (cfg_valid) begin
          shadow <= {shadow[TT_W-2:0], cfg_bit};
          count <= CW'(1);
          state <= LOAD;
        end
        LOAD: if (cfg_abort) begin
          count <= '0;
          state <= IDLE;
        end else if (cfg_valid) begin
          shadow <= {shadow[TT_W-2:0], cfg_bit};
          count <= count + 1'b1;
          if (count == CW'(TT_W - 1)) state <= COMMIT;
        end
        default: begin
          count <= '0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: rtl/tt_logic_eval.sv
// tt_logic_eval: registered N_IN-input truth-table gate with serial reprogramming
// Define TT_READBACK_EN to expose the active table on tt_active.
module tt_logic_eval
  import tt_eval_pkg::*;
#(
  parameter int N_IN = 4,
  parameter int TT_W = tt_width(N_IN),
  parameter logic [TT_W-1:0] TT_INIT = TT_W'(16'h4BF8)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N_IN-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_bit,
  input  logic            cfg_valid,
  output logic            cfg_ready,
  input  logic            cfg_bit,
  input  logic            cfg_abort,
  output logic            cfg_busy
`ifdef TT_READBACK_EN
  , output logic [TT_W-1:0] tt_active
`endif
);
  logic [TT_W-1:0] active, shadow;
  logic commit;
  tt_cfg_loader #(.TT_W(TT_W)) u_loader (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_bit(cfg_bit), .cfg_abort(cfg_abort), .cfg_busy(cfg_busy),
    .commit(commit), .shadow(shadow)
  );
  assign in_ready = !out_valid | out_ready;
`ifdef TT_READBACK_EN
  assign tt_active = active;
`endif
  // active only changes at the end of COMMIT, so a same-cycle eval sees the old table
  always_ff @(posedge clk) begin
    if (rst) active <= TT_INIT;
    else if (commit) active <= shadow;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_bit <= 1'b0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      out_bit <= active[in_data];
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_tt_logic_eval.sv
// tb_tt_logic_eval: directed checks of eval, backpressure, serial load, commit atomicity, abort and reset
module tb_tt_logic_eval;
  logic clk = 0, rst = 1;
  logic in_valid = 0, in_ready, out_valid, out_ready = 1, out_bit;
  logic [3:0] in_data = 0;
  logic cfg_valid = 0, cfg_ready, cfg_bit = 0, cfg_abort = 0, cfg_busy;
  logic in_valid_b = 0, in_ready_b, out_valid_b, out_bit_b;
  logic [1:0] in_data_b = 0;
  logic cfg_valid_b = 0, cfg_ready_b, cfg_bit_b = 0, cfg_busy_b;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  tt_logic_eval dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_bit(out_bit),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_bit(cfg_bit),
    .cfg_abort(cfg_abort), .cfg_busy(cfg_busy)
  );

  tt_logic_eval #(.N_IN(2), .TT_INIT(4'h6)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
    .out_valid(out_valid_b), .out_ready(1'b1), .out_bit(out_bit_b),
    .cfg_valid(cfg_valid_b), .cfg_ready(cfg_ready_b), .cfg_bit(cfg_bit_b),
    .cfg_abort(1'b0), .cfg_busy(cfg_busy_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic eval(input logic [3:0] v, input logic exp, input string tag);
    in_data = v;
    in_valid = 1;
    tick();
    in_valid = 0;
    chk({tag, "_valid"}, out_valid, 1);
    chk(tag, out_bit, exp);
  endtask

  task automatic load(input logic [15:0] w, input int beats);
    for (int i = 15; i > 15 - beats; i--) begin
      cfg_valid = 1;
      cfg_bit = w[i];
      tick();
    end
    cfg_valid = 0;
  endtask

  initial begin
    logic [3:0] vec [6] = '{4'h0, 4'h3, 4'h8, 4'hB, 4'hE, 4'hF};
    logic exp1 [6] = '{0, 1, 1, 1, 1, 0};
    logic [3:0] b_tt;
    tick();
    tick();
    rst = 0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_bit", out_bit, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_cfg_busy", cfg_busy, 0);
    // back-to-back vectors at full throughput
    in_valid = 1;
    for (int i = 0; i < 6; i++) begin
      in_data = vec[i];
      tick();
      chk($sformatf("t1_vec%0h", vec[i]), out_bit, exp1[i]);
      chk("t1_valid", out_valid, 1);
    end
    // backpressure
    in_data = 4'h3;
    tick();
    chk("t2_first", out_bit, 1);
    out_ready = 0;
    in_data = 4'h0;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("t2_in_ready", in_ready, 0);
      chk("t2_hold_bit", out_bit, 1);
      chk("t2_hold_valid", out_valid, 1);
      tick();
    end
    out_ready = 1;
    #1;
    chk("t2_release_ready", in_ready, 1);
    tick();
    chk("t2_next_vec", out_bit, 0);
    in_valid = 0;
    tick();
    chk("t2_drain", out_valid, 0);
    // serial load of 16'h8000 with commit atomicity
    load(16'h8000, 16);
    chk("t3_commit_ready", cfg_ready, 0);
    chk("t3_commit_busy", cfg_busy, 1);
    eval(4'h3, 1, "t4_commit_old");
    chk("t3_idle_ready", cfg_ready, 1);
    chk("t3_idle_busy", cfg_busy, 0);
    eval(4'h3, 0, "t4_new");
    eval(4'hF, 1, "t3_f");
    eval(4'hE, 0, "t3_e");
    // abort after 7 beats; aborting beat is dropped
    load(16'h0000, 7);
    chk("t5_load_busy", cfg_busy, 1);
    cfg_abort = 1;
    cfg_valid = 1;
    tick();
    cfg_abort = 0;
    cfg_valid = 0;
    chk("t5_abort_busy", cfg_busy, 0);
    eval(4'hF, 1, "t5_unchanged");
    load(16'h0008, 15);
    chk("t5_15_busy", cfg_busy, 1);
    chk("t5_15_ready", cfg_ready, 1);
    load(16'h0001, 1);
    chk("t5_16_ready", cfg_ready, 0);
    tick();
    eval(4'h3, 1, "t5_new3");
    eval(4'hF, 0, "t5_newf");
    // reset mid-load restores TT_INIT
    load(16'hFFFF, 10);
    rst = 1;
    tick();
    rst = 0;
    chk("t6_rst_busy", cfg_busy, 0);
    chk("t6_rst_valid", out_valid, 0);
    eval(4'h8, 1, "t6_init8");
    eval(4'h3, 1, "t6_init3");
    eval(4'hF, 0, "t6_initf");
    // N_IN=2 build: XOR default, then reload with AND
    for (int i = 0; i < 4; i++) begin
      in_data_b = 2'(i);
      in_valid_b = 1;
      tick();
      chk($sformatf("t6_xor%0d", i), out_bit_b, logic'(i == 1 || i == 2));
    end
    in_valid_b = 0;
    b_tt = 4'h8;
    for (int i = 3; i >= 0; i--) begin
      cfg_valid_b = 1;
      cfg_bit_b = b_tt[i];
      tick();
    end
    cfg_valid_b = 0;
    chk("t6_b_commit_ready", cfg_ready_b, 0);
    tick();
    chk("t6_b_busy", cfg_busy_b, 0);
    in_valid_b = 1;
    in_data_b = 2'd3;
    tick();
    chk("t6_and3", out_bit_b, 1);
    in_data_b = 2'd1;
    tick();
    chk("t6_and1", out_bit_b, 0);
    in_valid_b = 0;
    chk("t6_b_ready", in_ready_b, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
